mem_port_arbiter: RTL

//  Shares the single DPI-backed memory port between the instruction-fetch requester (IF, read-only) and
//  the load/store requester (LS) of the multi-cycle core. One transaction outstanding at a time.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter: FSM states, requester
// identity, access-size codes and the misalignment rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Size code 2'b11 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = addr_lo[0];
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store strobes/data replication and
// load lane selection with sign or zero extension.
module lsu_lane_align
  import mem_arb_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    wstrb      = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    byte_sel   = rdata[{addr_lo, 3'b000} +: 8];
    half_sel   = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B: begin
        wstrb      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
    if (!we) wstrb = 4'b0000;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// one transaction in flight, with starvation protection for fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic              ls_unsigned,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  state_t            state_q, state_d;
  owner_t            owner_q;
  logic [CNT_W-1:0]  starve_q;
  logic              we_q, unsigned_q, fault_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic              ls_fault;
  logic [3:0]        strb_lane;
  logic [31:0]       wdata_lane, rdata_ext;

  assign ls_fault = is_misaligned(ls_size, ls_addr[1:0]);

  always_comb begin
    state_d = state_q;
    if_gnt  = 1'b0;
    ls_gnt  = 1'b0;
    case (state_q)
      IDLE: begin
        // A waiting fetch that has lost STARVE_MAX times in a row overrides LS.
        if (!rst && ls_req && !(if_req && starve_q == CNT_MAX)) begin
          ls_gnt  = 1'b1;
          state_d = ls_fault ? RESP : ISSUE;
        end else if (!rst && if_req) begin
          if_gnt  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   if (mem_ready) state_d = WAIT;
      WAIT:    if (mem_rvalid) state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too; they drive outputs directly
    // and every output must read zero straight out of reset.
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      starve_q   <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      fault_q    <= 1'b0;
      size_q     <= SZ_B;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (!if_req || if_gnt) starve_q <= '0;
      else if (ls_gnt && starve_q != CNT_MAX) starve_q <= starve_q + 1'b1;
      if (ls_gnt) begin
        owner_q    <= OWN_LS;
        we_q       <= ls_we;
        size_q     <= ls_size;
        unsigned_q <= ls_unsigned;
        addr_q     <= ls_addr;
        wdata_q    <= ls_wdata;
        fault_q    <= ls_fault;
      end else if (if_gnt) begin
        owner_q    <= OWN_IF;
        we_q       <= 1'b0;
        size_q     <= SZ_W;
        unsigned_q <= 1'b0;
        addr_q     <= {if_addr[ADDR_W-1:2], 2'b00};
        wdata_q    <= '0;
        fault_q    <= 1'b0;
      end
      if (state_q == WAIT && mem_rvalid) rdata_q <= mem_rdata;
    end
  end

  lsu_lane_align u_align (
    .we          (we_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .rdata       (rdata_q),
    .wstrb       (strb_lane),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext)
  );

  assign busy      = (state_q != IDLE);
  assign mem_req   = (state_q == ISSUE);
  assign mem_we    = mem_req && we_q;
  assign mem_wstrb = mem_req ? strb_lane : 4'b0000;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = wdata_lane;

  assign if_rvalid   = (state_q == RESP) && (owner_q == OWN_IF);
  assign if_rdata    = if_rvalid ? rdata_q : 32'b0;
  assign ls_rvalid   = (state_q == RESP) && (owner_q == OWN_LS);
  assign ls_misalign = ls_rvalid && fault_q;
  assign ls_rdata    = (ls_rvalid && !we_q && !fault_q) ? rdata_ext : 32'b0;

endmodule
